// File: rtl/fdma_pkg.sv
// Shared types and constants for the FDMA read/write arbiter slice.
package fdma_pkg;

    localparam int unsigned NUM_WCH = 4;
    localparam int unsigned RD_BIT  = 4;
    localparam int unsigned GRANT_W = NUM_WCH + 1;
    localparam int unsigned SIZE_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_e;

    // Index of the set bit of a one-hot write-channel vector (0 when empty).
    function automatic logic [1:0] onehot_idx(input logic [NUM_WCH-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_WCH; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fdma_rr_pick.sv
// Combinational 4-way round-robin picker: first requester at or after ptr_i.
module fdma_rr_pick
    import fdma_pkg::*;
(
    input  logic [NUM_WCH-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_WCH-1:0] gnt_o,
    output logic               valid_o
);

    logic [1:0] idx;

    // Scan requests starting at the pointer, wrapping modulo 4.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < NUM_WCH; i++) begin
            idx = ptr_i + 2'(i);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fdma_rw_arbiter.sv
// Arbitrates one FDMA engine between four write channels and one display read.
module fdma_rw_arbiter
    import fdma_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 23,
    parameter int unsigned READ_MAX       = 4,
    parameter int unsigned ACK_TIMEOUT    = 1023
) (
    input  logic                               ui_clk,
    input  logic                               ui_rstn,
    input  logic [NUM_WCH-1:0]                 wareq_i,
    input  logic [NUM_WCH*AXI_ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WCH*SIZE_W-1:0]          wsize_i,
    input  logic [NUM_WCH*AXI_DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_WCH-1:0]                 wbusy_o,
    output logic [NUM_WCH-1:0]                 wvalid_o,
    input  logic                               rareq_i,
    input  logic [AXI_ADDR_WIDTH-1:0]          raddr_i,
    input  logic [SIZE_W-1:0]                  rsize_i,
    output logic                               rbusy_o,
    output logic                               rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]          rdata_o,
    output logic [AXI_ADDR_WIDTH-1:0]          fdma_waddr,
    output logic [SIZE_W-1:0]                  fdma_wsize,
    output logic [AXI_DATA_WIDTH-1:0]          fdma_wdata,
    output logic                               fdma_wareq,
    input  logic                               fdma_wbusy,
    input  logic                               fdma_wvalid,
    output logic [AXI_ADDR_WIDTH-1:0]          fdma_raddr,
    output logic [SIZE_W-1:0]                  fdma_rsize,
    output logic                               fdma_rareq,
    input  logic                               fdma_rbusy,
    input  logic                               fdma_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]          fdma_rdata,
    output logic [GRANT_W-1:0]                 grant_o,
    output logic                               err_timeout_o
);

    localparam int unsigned STRK_W = $clog2(READ_MAX + 1);
    localparam int unsigned WDOG_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [GRANT_W-1:0] RD_GRANT = GRANT_W'(1) << RD_BIT;

    state_e              state_q;
    logic [GRANT_W-1:0]  grant_q;
    logic                wareq_q;
    logic                rareq_q;
    logic [1:0]          rr_ptr_q;
    logic [STRK_W-1:0]   streak_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic                err_q;

    logic [NUM_WCH-1:0]  pick_gnt;
    logic                pick_valid;
    logic                write_pending;
    logic                read_wins;
    logic                eng_busy;

    fdma_rr_pick u_pick (
        .req_i   (wareq_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // Read priority, bounded by the streak counter only while a write waits.
    always_comb begin
        write_pending = |wareq_i;
        read_wins     = rareq_i && ((streak_q < STRK_W'(READ_MAX)) || !write_pending);
        eng_busy      = grant_q[RD_BIT] ? fdma_rbusy : fdma_wbusy;
    end

    // Burst sequencer: arbitration, engine request, watchdog and transfer hold.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            wareq_q  <= 1'b0;
            rareq_q  <= 1'b0;
            rr_ptr_q <= 2'd0;
            streak_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_wins) begin
                        state_q <= REQ;
                        grant_q <= RD_GRANT;
                        rareq_q <= 1'b1;
                        wdog_q  <= WDOG_W'(1);
                        if (streak_q != STRK_W'(READ_MAX)) begin
                            streak_q <= streak_q + STRK_W'(1);
                        end
                    end else if (pick_valid) begin
                        state_q  <= REQ;
                        grant_q  <= {1'b0, pick_gnt};
                        wareq_q  <= 1'b1;
                        wdog_q   <= WDOG_W'(1);
                        streak_q <= '0;
                        rr_ptr_q <= onehot_idx(pick_gnt) + 2'd1;
                    end
                end
                REQ: begin
                    if (eng_busy) begin
                        state_q <= XFER;
                        wareq_q <= 1'b0;
                        rareq_q <= 1'b0;
                    end else if (wdog_q == WDOG_W'(ACK_TIMEOUT)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        wareq_q <= 1'b0;
                        rareq_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                XFER: begin
                    if (!eng_busy) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    wareq_q <= 1'b0;
                    rareq_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload mux and status routing driven from the registered grant.
    always_comb begin
        fdma_waddr = '0;
        fdma_wsize = '0;
        fdma_wdata = '0;
        for (int k = 0; k < NUM_WCH; k++) begin
            if (grant_q[k]) begin
                fdma_waddr = waddr_i[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                fdma_wsize = wsize_i[k*SIZE_W +: SIZE_W];
                fdma_wdata = wdata_i[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
        wbusy_o    = grant_q[NUM_WCH-1:0] & {NUM_WCH{fdma_wbusy}};
        wvalid_o   = grant_q[NUM_WCH-1:0] & {NUM_WCH{fdma_wvalid}};
        rbusy_o    = grant_q[RD_BIT] & fdma_rbusy;
        rvalid_o   = grant_q[RD_BIT] & fdma_rvalid;
        rdata_o    = fdma_rdata;
        fdma_raddr = raddr_i;
        fdma_rsize = rsize_i;
    end

    assign grant_o       = grant_q;
    assign fdma_wareq    = wareq_q;
    assign fdma_rareq    = rareq_q;
    assign err_timeout_o = err_q;

endmodule

// File: doc/fdma_rw_arbiter.md
# fdma_rw_arbiter

Shares one FDMA engine (single SDRAM port) between four video write channels and one display read channel. It sits between the per-channel frame-buffer controllers and the FDMA engine, and decides which channel's burst goes next. Reads have fixed priority so the display does not underrun, with a bounded starvation guard for writes. Writes are served round-robin. The per-request burst handshake is sequenced by a state machine, with a watchdog on engine acceptance.

## Interface
- AXI_DATA_WIDTH, 32, FDMA data width
- AXI_ADDR_WIDTH, 23, FDMA address width
- READ_MAX, 4, consecutive read grants allowed while any write is pending
- ACK_TIMEOUT, 1023, cycles to wait in REQ for engine busy before abort
- ui_clk  in  1  sole clock
- ui_rstn  in  1  asynchronous, active-low reset
- wareq_i  in  4  write requests, level, one bit per channel
- waddr_i  in  4*AXI_ADDR_WIDTH  channel k in slice k
- wsize_i  in  4*16  burst length per channel
- wdata_i  in  4*AXI_DATA_WIDTH  write data per channel
- wbusy_o  out  4  engine wbusy, routed to granted channel only
- wvalid_o  out  4  engine wvalid, routed to granted channel only
- rareq_i, raddr_i, rsize_i  in  1 / AXI_ADDR_WIDTH / 16  read request
- rbusy_o, rvalid_o  out  1  read handshake back to requester
- rdata_o  out  AXI_DATA_WIDTH  engine rdata passed through
- fdma_waddr, fdma_wsize, fdma_wdata  out  — engine write side
- fdma_wareq  out  1  engine write request
- fdma_wbusy, fdma_wvalid  in  1  engine write status
- fdma_raddr, fdma_rsize  out  — engine read side
- fdma_rareq  out  1  engine read request
- fdma_rbusy, fdma_rvalid  in  1  engine read status
- fdma_rdata  in  AXI_DATA_WIDTH  engine read data
- grant_o  out  5  one-hot owner: bits 0-3 write channels, bit 4 read; 0 when idle
- err_timeout_o  out  1  sticky; set on watchdog abort

## Operation
- States:
  - IDLE: evaluates requests. If any request is present, latch the winner into grant and go to REQ.
  - REQ: drive the winner's areq to the engine. When the engine busy goes 1, go to XFER. If the watchdog reaches ACK_TIMEOUT, set err_timeout_o and go to IDLE.
  - XFER: hold grant until the engine busy goes 0, then go to IDLE.
- Selection in IDLE:
  - If rareq_i=1 and the read-streak counter is below READ_MAX (or no write is pending), read wins.
  - Otherwise the lowest write index at or after rr_ptr (mod 4) with wareq_i=1 wins.
- Counter and pointer updates:
  - Read-streak counter increments on each read grant and clears on each write grant.
  - rr_ptr becomes winner+1 (mod 4) on a write grant and is unchanged on a read grant.
- Address, size and data are muxed by registered grant. Non-granted channels see busy=0 and valid=0.
- Only one of fdma_wareq and fdma_rareq is ever 1. Both are 0 outside REQ.
- Requests that drop in REQ before engine busy rises do not cancel the grant; the engine owns the burst once areq is seen.
- Reset values: state IDLE, grant_o=0, fdma_wareq=fdma_rareq=0, rr_ptr=0, streak=0, err_timeout_o=0. Routed busy and valid outputs are 0.
- Reset asserted mid-XFER returns to IDLE immediately. The engine is reset by the same ui_rstn.

## Timing
- Request sampled in IDLE at cycle n gives grant_o and engine areq at n+1: 1-cycle arbitration latency.
- Busy, valid and rdata routing is combinational from registered grant: 0-cycle pass-through.
- After busy falls at cycle m: IDLE at m+1, next grant at m+2. Minimum 2 dead cycles between bursts.
- Watchdog counts cycles in REQ from 1. Abort happens on the cycle the count equals ACK_TIMEOUT.
- A read and a write asserted in the same IDLE cycle: read wins (subject to READ_MAX).

## Structure
- Shared package fdma_pkg holds:
  - state enum {IDLE, REQ, XFER}
  - the channel count constant (4) and the read-bit index (4)
  - the FDMA size width (16)
- One sub-module, fdma_rr_pick: pure combinational 4-way round-robin picker taking req[3:0] and ptr[1:0] and returning one-hot gnt and a valid flag.

## Test plan
- Single write: wareq_i=0001, engine raises busy 2 cycles after areq and holds it 256 cycles.
  - Expect grant_o=00001 one cycle after request; fdma_waddr equals waddr_i slice 0.
  - Expect wbusy_o=0001 during the burst and IDLE after it.
- All four writes held, no read.
  - Expect grants in order 0,1,2,3,0, with rr_ptr wrapping 3 to 0.
- Read starvation guard: rareq_i and wareq_i=0100 held continuously, READ_MAX=4.
  - Expect grant sequence R,R,R,R,W2,R,R,R,R,W2.
- Simultaneous read and write arriving in the same IDLE cycle: expect read granted first.
- Engine never raises busy: expect fdma_wareq=1 for 1023 cycles, then err_timeout_o=1 and grant_o=0.
  - Then the next request is arbitrated normally.
- ui_rstn pulsed low mid-XFER: expect all outputs at reset values asynchronously and rr_ptr=0.
